// File: rtl/v6_filter_ctrl_pkg.sv
// Shared constants and types for the v6 trapezoidal shaping filter and its controller.
// Holds the default coefficient set that the filter powers up with and the
// controller state encoding. Nothing here produces hardware on its own.
package v6_filter_ctrl_pkg;

    // Port widths of the v6 filter instance.
    localparam int K_W_6 = 6;
    localparam int M_W_6 = 8;

    // Sample-history depth of the filter; a legal l satisfies l+1 < SAVE_DEPTH_6.
    localparam int saveDataSize = 31;
    localparam int SAVE_DEPTH_6 = saveDataSize + 1;

    // Filter pipeline latency (input to output register), in clk cycles.
    localparam int PIPE_LAT_6 = 8;

    // Cycles the filter is held in reset on each reconfiguration.
    localparam int FLUSH_CYC_6 = 2;

    // Default coefficient set, active after reset until something else is loaded.
    localparam logic [K_W_6-1:0] k_6  = 6'd6;
    localparam logic [K_W_6-1:0] l_6  = 6'd16;
    localparam logic [M_W_6-1:0] m1_6 = 8'd64;
    localparam logic [M_W_6-1:0] m2_6 = 8'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        WARMUP = 3'd3,
        RUN    = 3'd4
    } v6_ctrl_state_t;

endpackage

// File: rtl/v6_filter_ctrl_if.sv
// Coefficient-set channel between the slow-control register block (master)
// and the v6 filter controller (slave).
//   cfg_valid        master -> slave  a coefficient set is offered
//   cfg_k/l/m1/m2    master -> slave  the offered set, stable while cfg_valid=1
//   cfg_ready        slave  -> master controller can take a set this cycle
//   cfg_err          slave  -> master one-cycle pulse: the last accepted set was rejected
//
// Handshake: a set transfers on a rising clk edge where cfg_valid && cfg_ready.
// The master holds cfg_valid and the data stable until that edge; the slave may
// change cfg_ready at any time and the master must not wait on cfg_ready before
// raising cfg_valid. Exactly one set transfers per cycle with both high.
interface v6_filter_ctrl_if #(
    parameter int K_W = 6,
    parameter int M_W = 8
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [K_W-1:0] cfg_k;
    logic [K_W-1:0] cfg_l;
    logic [M_W-1:0] cfg_m1;
    logic [M_W-1:0] cfg_m2;
    logic           cfg_err;

    modport master (
        output cfg_valid, cfg_k, cfg_l, cfg_m1, cfg_m2,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_k, cfg_l, cfg_m1, cfg_m2,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/v6_filter_ctrl_warmup_counter.sv
// Warm-up down-counter for shaping-filter sequencers.
// A load strobe arms the counter with load_val_i; it then counts down once per
// cycle and raises done_o for exactly one cycle while the count sits at zero,
// i.e. load_val_i+1 cycles after the load edge. A new load restarts it.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load_i         load strobe
//   load_val_i     value loaded on load_i
//   done_o         one-cycle pulse when the armed count reaches zero
module v6_warmup_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load_i) begin
            cnt_d   = load_val_i;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/v6_filter_ctrl.sv
// Sequencer/configurator for the v6 trapezoidal shaping filter.
// Accepts coefficient sets over the cfg channel, range-checks them, holds the
// filter in reset while coefficients change and times the warm-up so out_valid
// rises only once the shaper output has settled.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   run_en         1 = filter may run, 0 = hold filter in reset (config retained)
//   cfg            coefficient-set channel (slave side)
//   filt_reset     active-low reset to the filter instance
//   filt_k/l/m1/m2 active coefficients to the filter
//   out_valid      filter output settled and valid
//   busy           controller is in LOAD, FLUSH or WARMUP
//   state_o        current controller state (debug)
module v6_filter_ctrl
    import v6_filter_ctrl_pkg::*;
#(
    parameter int K_W        = K_W_6,
    parameter int M_W        = M_W_6,
    parameter int SAVE_DEPTH = SAVE_DEPTH_6,
    parameter int PIPE_LAT   = PIPE_LAT_6,
    parameter int FLUSH_CYC  = FLUSH_CYC_6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run_en,
    v6_filter_ctrl_if.slave cfg,
    output logic           filt_reset,
    output logic [K_W-1:0] filt_k,
    output logic [K_W-1:0] filt_l,
    output logic [M_W-1:0] filt_m1,
    output logic [M_W-1:0] filt_m2,
    output logic           out_valid,
    output logic           busy,
    output v6_ctrl_state_t state_o
);

    // Worst case k+l+PIPE_LAT for K_W-bit k and l fits with a bit to spare.
    localparam int CNT_W = K_W + 1 + $clog2(PIPE_LAT) + 1;
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    v6_ctrl_state_t state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            src_run_q, src_run_d;      // LOAD was entered from RUN
    logic            cfg_loaded_q, cfg_loaded_d;

    // Staging bank: the set captured on accept, checked during LOAD.
    logic [K_W-1:0] stage_k_q, stage_k_d, stage_l_q, stage_l_d;
    logic [M_W-1:0] stage_m1_q, stage_m1_d, stage_m2_q, stage_m2_d;
    // Pending bank: last legal set, waiting for the next FLUSH.
    logic [K_W-1:0] pend_k_q, pend_k_d, pend_l_q, pend_l_d;
    logic [M_W-1:0] pend_m1_q, pend_m1_d, pend_m2_q, pend_m2_d;
    // Active bank: what the filter currently sees.
    logic [K_W-1:0] act_k_q, act_k_d, act_l_q, act_l_d;
    logic [M_W-1:0] act_m1_q, act_m1_d, act_m2_q, act_m2_d;

    logic filt_reset_q, filt_reset_d;
    logic out_valid_q, out_valid_d;
    logic busy_q, busy_d;
    logic rdy_q, rdy_d;
    logic err_q, err_d;

    logic             cfg_ready_int;
    logic             accept;
    logic             legal;
    logic             have_cfg;
    logic             warm_load;
    logic             warm_done;
    logic [CNT_W-1:0] warm_val;

    // run_en has priority over an accept in RUN, so ready is gated combinationally.
    assign cfg_ready_int = rdy_q && !((state_q == RUN) && !run_en);
    assign accept        = cfg.cfg_valid && cfg_ready_int;

    assign legal = (stage_k_q != '0)
                && (stage_l_q >= stage_k_q)
                && ((32'(stage_l_q) + 32'd1) < 32'(SAVE_DEPTH))
                && (stage_m1_q != '0);

    // The default set counts as loaded from reset onward.
    assign have_cfg = cfg_loaded_q || 1'b1;

    // Loaded on the FLUSH->WARMUP edge, by which point the active bank is final.
    assign warm_val = CNT_W'(act_k_q) + CNT_W'(act_l_q) + CNT_W'(PIPE_LAT);

    v6_warmup_counter #(
        .CNT_W (CNT_W)
    ) u_warmup (
        .clk        (clk),
        .reset      (reset),
        .load_i     (warm_load),
        .load_val_i (warm_val),
        .done_o     (warm_done)
    );

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        src_run_d    = src_run_q;
        cfg_loaded_d = cfg_loaded_q;
        stage_k_d    = stage_k_q;
        stage_l_d    = stage_l_q;
        stage_m1_d   = stage_m1_q;
        stage_m2_d   = stage_m2_q;
        pend_k_d     = pend_k_q;
        pend_l_d     = pend_l_q;
        pend_m1_d    = pend_m1_q;
        pend_m2_d    = pend_m2_q;
        err_d        = 1'b0;
        warm_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = LOAD;
                    src_run_d  = 1'b0;
                    stage_k_d  = cfg.cfg_k;
                    stage_l_d  = cfg.cfg_l;
                    stage_m1_d = cfg.cfg_m1;
                    stage_m2_d = cfg.cfg_m2;
                end else if (run_en && have_cfg) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            LOAD: begin
                if (legal) begin
                    pend_k_d     = stage_k_q;
                    pend_l_d     = stage_l_q;
                    pend_m1_d    = stage_m1_q;
                    pend_m2_d    = stage_m2_q;
                    cfg_loaded_d = 1'b1;
                    if (run_en) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = src_run_q ? RUN : IDLE;
                end
            end
            FLUSH: begin
                if (!run_en) begin
                    state_d = IDLE;
                end else if (flush_cnt_q == FC_W'(FLUSH_CYC - 1)) begin
                    state_d   = WARMUP;
                    warm_load = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            WARMUP: begin
                if (!run_en) begin
                    state_d = IDLE;
                end else if (warm_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run_en) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d    = LOAD;
                    src_run_d  = 1'b1;
                    stage_k_d  = cfg.cfg_k;
                    stage_l_d  = cfg.cfg_l;
                    stage_m1_d = cfg.cfg_m1;
                    stage_m2_d = cfg.cfg_m2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, derived from the state being entered.
    always_comb begin
        act_k_d      = act_k_q;
        act_l_d      = act_l_q;
        act_m1_d     = act_m1_q;
        act_m2_d     = act_m2_q;
        filt_reset_d = 1'b0;
        out_valid_d  = 1'b0;
        busy_d       = 1'b0;
        rdy_d        = 1'b0;

        // Active coefficients change only on the edge that enters FLUSH, the
        // same edge that pulls filt_reset low.
        if ((state_d == FLUSH) && (state_q != FLUSH)) begin
            act_k_d  = pend_k_d;
            act_l_d  = pend_l_d;
            act_m1_d = pend_m1_d;
            act_m2_d = pend_m2_d;
        end

        case (state_d)
            IDLE: begin
                rdy_d = 1'b1;
            end
            LOAD: begin
                // A check started from RUN must not disturb the running filter.
                filt_reset_d = filt_reset_q;
                out_valid_d  = out_valid_q;
                busy_d       = 1'b1;
            end
            FLUSH: begin
                busy_d = 1'b1;
            end
            WARMUP: begin
                filt_reset_d = 1'b1;
                busy_d       = 1'b1;
            end
            RUN: begin
                filt_reset_d = 1'b1;
                out_valid_d  = 1'b1;
                rdy_d        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            src_run_q    <= 1'b0;
            cfg_loaded_q <= 1'b0;
            stage_k_q    <= '0;
            stage_l_q    <= '0;
            stage_m1_q   <= '0;
            stage_m2_q   <= '0;
            pend_k_q     <= K_W'(k_6);
            pend_l_q     <= K_W'(l_6);
            pend_m1_q    <= M_W'(m1_6);
            pend_m2_q    <= M_W'(m2_6);
            act_k_q      <= K_W'(k_6);
            act_l_q      <= K_W'(l_6);
            act_m1_q     <= M_W'(m1_6);
            act_m2_q     <= M_W'(m2_6);
            filt_reset_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            rdy_q        <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            src_run_q    <= src_run_d;
            cfg_loaded_q <= cfg_loaded_d;
            stage_k_q    <= stage_k_d;
            stage_l_q    <= stage_l_d;
            stage_m1_q   <= stage_m1_d;
            stage_m2_q   <= stage_m2_d;
            pend_k_q     <= pend_k_d;
            pend_l_q     <= pend_l_d;
            pend_m1_q    <= pend_m1_d;
            pend_m2_q    <= pend_m2_d;
            act_k_q      <= act_k_d;
            act_l_q      <= act_l_d;
            act_m1_q     <= act_m1_d;
            act_m2_q     <= act_m2_d;
            filt_reset_q <= filt_reset_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            rdy_q        <= rdy_d;
            err_q        <= err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_int;
    assign cfg.cfg_err   = err_q;
    assign filt_reset    = filt_reset_q;
    assign filt_k        = act_k_q;
    assign filt_l        = act_l_q;
    assign filt_m1       = act_m1_q;
    assign filt_m2       = act_m2_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_v6_filter_ctrl.sv
// Directed testbench for v6_filter_ctrl.
module tb_v6_filter_ctrl;
    import v6_filter_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic run_en = 1'b0;
    always #5 clk = ~clk;

    v6_filter_ctrl_if #(.K_W(K_W_6), .M_W(M_W_6)) cfg_if ();

    logic             filt_reset;
    logic [K_W_6-1:0] filt_k, filt_l;
    logic [M_W_6-1:0] filt_m1, filt_m2;
    logic             out_valid, busy;
    v6_ctrl_state_t   state;

    v6_filter_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .cfg        (cfg_if),
        .filt_reset (filt_reset),
        .filt_k     (filt_k),
        .filt_l     (filt_l),
        .filt_m1    (filt_m1),
        .filt_m2    (filt_m2),
        .out_valid  (out_valid),
        .busy       (busy),
        .state_o    (state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];   // expected WARMUP lengths, hand-computed (k+l+8+1)

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a set for one edge; the caller guarantees cfg_ready is high.
    task automatic send_cfg(input logic [5:0] k, input logic [5:0] l,
                            input logic [7:0] m1, input logic [7:0] m2);
        cfg_if.cfg_k     = k;
        cfg_if.cfg_l     = l;
        cfg_if.cfg_m1    = m1;
        cfg_if.cfg_m2    = m2;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Called on the first observed WARMUP cycle; counts cycles to out_valid.
    task automatic run_expect(input string tag);
        int n;
        logic [31:0] exp;
        n   = 0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        while (out_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check(tag, n, exp);
        check({tag, "_state"}, state, RUN);
    endtask

    // From the first LOAD cycle of a legal set with run_en=1, walk to WARMUP entry.
    task automatic load_to_warmup(input string tag, input logic [5:0] k);
        step();
        check({tag, "_flush1_state"}, state, FLUSH);
        check({tag, "_flush1_frst"}, filt_reset, 0);
        check({tag, "_flush1_k"}, filt_k, k);
        check({tag, "_flush1_ov"}, out_valid, 0);
        step();
        check({tag, "_flush2_frst"}, filt_reset, 0);
        step();
        check({tag, "_warm_state"}, state, WARMUP);
        check({tag, "_warm_frst"}, filt_reset, 1);
        check({tag, "_warm_k"}, filt_k, k);
    endtask

    logic [5:0] bad_k [4] = '{6'd0, 6'd5, 6'd4, 6'd4};
    logic [5:0] bad_l [4] = '{6'd10, 6'd3, 6'd31, 6'd10};
    logic [7:0] bad_m1[4] = '{8'd3, 8'd3, 8'd3, 8'd0};

    // ---------------- stimulus ----------------
    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_k     = '0;
        cfg_if.cfg_l     = '0;
        cfg_if.cfg_m1    = '0;
        cfg_if.cfg_m2    = '0;
        run_en = 1'b1;
        reset  = 1'b0;
        steps(2);

        // Reset values (defaults k=6, l=16, m1=64, m2=32)
        check("rst_state", state, IDLE);
        check("rst_frst", filt_reset, 0);
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_if.cfg_err, 0);
        check("rst_ready", cfg_if.cfg_ready, 1);
        check("rst_k", filt_k, 6);
        check("rst_l", filt_l, 16);
        check("rst_m1", filt_m1, 64);
        check("rst_m2", filt_m2, 32);

        // 1: defaults start on run_en; WARMUP = 6+16+8+1 = 31
        reset = 1'b1;
        step();
        check("t1_state", state, FLUSH);
        check("t1_busy", busy, 1);
        check("t1_frst1", filt_reset, 0);
        step();
        check("t1_frst2", filt_reset, 0);
        step();
        check("t1_warm", state, WARMUP);
        check("t1_frst_hi", filt_reset, 1);
        exp_q.push_back(32'd31);
        run_expect("t1_warm_len");
        check("t1_busy_run", busy, 0);
        check("t1_ready_run", cfg_if.cfg_ready, 1);

        // 2: reconfigure from RUN; WARMUP = 4+10+8+1 = 23
        send_cfg(6'd4, 6'd10, 8'd3, 8'd5);
        check("t2_load", state, LOAD);
        check("t2_ready", cfg_if.cfg_ready, 0);
        check("t2_load_ov", out_valid, 1);
        check("t2_load_k", filt_k, 6);
        load_to_warmup("t2", 6'd4);
        exp_q.push_back(32'd23);
        run_expect("t2_warm_len");
        check("t2_l", filt_l, 10);
        check("t2_m1", filt_m1, 3);
        check("t2_m2", filt_m2, 5);

        // 3: illegal sets from RUN (k=0, l<k, l+1=32, m1=0)
        for (int i = 0; i < 4; i++) begin
            send_cfg(bad_k[i], bad_l[i], bad_m1[i], 8'd1);
            check($sformatf("t3_%0d_load", i), state, LOAD);
            check($sformatf("t3_%0d_load_ov", i), out_valid, 1);
            check($sformatf("t3_%0d_load_frst", i), filt_reset, 1);
            step();
            check($sformatf("t3_%0d_err", i), cfg_if.cfg_err, 1);
            check($sformatf("t3_%0d_state", i), state, RUN);
            check($sformatf("t3_%0d_ov", i), out_valid, 1);
            check($sformatf("t3_%0d_k", i), filt_k, 4);
            check($sformatf("t3_%0d_l", i), filt_l, 10);
            step();
            check($sformatf("t3_%0d_err_end", i), cfg_if.cfg_err, 0);
        end

        // 4: boundary-legal set k=30,l=30, run_en dropped in WARMUP; WARMUP = 30+30+8+1 = 69
        send_cfg(6'd30, 6'd30, 8'd1, 8'd0);
        load_to_warmup("t4a", 6'd30);
        steps(5);
        check("t4_warm_ov", out_valid, 0);
        run_en = 1'b0;
        step();
        check("t4_idle", state, IDLE);
        check("t4_idle_ov", out_valid, 0);
        check("t4_idle_frst", filt_reset, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_k", filt_k, 30);
        steps(3);
        check("t4_idle_hold", state, IDLE);
        run_en = 1'b1;
        step();
        check("t4_reflush", state, FLUSH);
        check("t4_reflush_k", filt_k, 30);
        step();
        step();
        check("t4_rewarm", state, WARMUP);
        exp_q.push_back(32'd69);
        run_expect("t4_warm_len");
        check("t4_l", filt_l, 30);

        // 5: cfg_valid offered as run_en drops in RUN -> no accept
        cfg_if.cfg_k     = 6'd2;
        cfg_if.cfg_l     = 6'd2;
        cfg_if.cfg_m1    = 8'd7;
        cfg_if.cfg_m2    = 8'd9;
        cfg_if.cfg_valid = 1'b1;
        run_en           = 1'b0;
        #1;
        check("t5_ready_gated", cfg_if.cfg_ready, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        check("t5_idle", state, IDLE);
        check("t5_ov", out_valid, 0);
        step();
        check("t5_err", cfg_if.cfg_err, 0);
        check("t5_state", state, IDLE);
        check("t5_k", filt_k, 30);

        // Load in IDLE with run_en=0; applied only at next FLUSH. WARMUP = 2+2+8+1 = 13
        send_cfg(6'd2, 6'd2, 8'd7, 8'd9);
        check("t5b_load", state, LOAD);
        step();
        check("t5b_idle", state, IDLE);
        check("t5b_err", cfg_if.cfg_err, 0);
        check("t5b_k_held", filt_k, 30);
        run_en = 1'b1;
        step();
        check("t5b_flush", state, FLUSH);
        check("t5b_k", filt_k, 2);
        check("t5b_m1", filt_m1, 7);
        step();
        step();
        check("t5b_warm", state, WARMUP);
        exp_q.push_back(32'd13);
        run_expect("t5b_warm_len");

        // 6: async reset mid-WARMUP
        send_cfg(6'd8, 6'd8, 8'd2, 8'd2);
        load_to_warmup("t6", 6'd8);
        steps(4);
        #2;
        reset = 1'b0;
        #1;
        check("t6_state", state, IDLE);
        check("t6_k", filt_k, 6);
        check("t6_l", filt_l, 16);
        check("t6_m1", filt_m1, 64);
        check("t6_ov", out_valid, 0);
        check("t6_frst", filt_reset, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", cfg_if.cfg_ready, 1);
        step();
        reset = 1'b1;
        step();
        check("t6_flush", state, FLUSH);
        step();
        step();
        check("t6_warm", state, WARMUP);
        exp_q.push_back(32'd31);
        run_expect("t6_warm_len");
        check("t6_k_run", filt_k, 6);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
